// File: rtl/seq_tnn_stream.sv
`timescale 1ns/1ps
// seq_tnn_stream
// Streaming two-layer ternary neural network engine. It accepts one feature
// vector, evaluates PAR hidden neurons per cycle, then scores one class per
// cycle while it keeps a running argmax, and presents the winning class index.
// The weights are elaboration-time parameters in a dense mask/sign encoding.
//
// Handshake: a transfer happens on any rising clk edge where valid and ready
// are both 1. in_ready is high only in IDLE. Once out_valid is raised,
// prediction stays stable until the edge where out_ready is also high.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   features   FEAT_CNT x FEAT_BITS unsigned; feature i at [i*FEAT_BITS +: FEAT_BITS]
//   in_valid   features valid
//   in_ready   engine accepts a new vector (IDLE only)
//   prediction winning class index, meaningful while out_valid=1
//   out_valid  prediction valid
//   out_ready  downstream accepts the prediction
//   score      (TNN_SCORE_OUT_EN only) signed score of the winning class
//
// Optional build macro: TNN_SCORE_OUT_EN adds the score output port.
module seq_tnn_stream #(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter int PAR        = 4,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_MASK = '0,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_SIGN = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_MASK = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_SIGN = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [$clog2(CLASS_CNT)-1:0]      prediction,
  output logic                              out_valid,
  input  logic                              out_ready
`ifdef TNN_SCORE_OUT_EN
  ,
  output logic signed [$clog2(HIDDEN_CNT)+1:0] score
`endif
);

  localparam int ACC_W   = FEAT_BITS + $clog2(FEAT_CNT) + 1;
  localparam int SCORE_W = $clog2(HIDDEN_CNT) + 2;
  localparam int G       = (HIDDEN_CNT + PAR - 1) / PAR;
  localparam int GRP_W   = (G > 1) ? $clog2(G) : 1;
  localparam int CLS_W   = $clog2(CLASS_CNT);
  localparam int FI_W    = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int HI_W    = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
  localparam int PI_W    = (PAR > 1) ? $clog2(PAR) : 1;
  localparam int W1I_W   = (FEAT_CNT*HIDDEN_CNT > 1) ? $clog2(FEAT_CNT*HIDDEN_CNT) : 1;
  localparam int W2I_W   = (HIDDEN_CNT*CLASS_CNT > 1) ? $clog2(HIDDEN_CNT*CLASS_CNT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HIDDEN = 2'd1;
  localparam logic [1:0] CLASS  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]                    state;
  logic [GRP_W-1:0]              grp;
  logic [CLS_W-1:0]              cls;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic [HIDDEN_CNT-1:0]         hidden_q;
  logic signed [SCORE_W-1:0]     best_score;
  logic [CLS_W-1:0]              best_idx;

  assign in_ready = (state == IDLE);

  // Layer 1: PAR neurons of the current group, evaluated combinationally.
  logic [FEAT_BITS-1:0]      feat_arr [FEAT_CNT];
  logic signed [ACC_W-1:0]   nsum     [PAR];
  logic                      nlive    [PAR];
  logic [HI_W-1:0]           nidx     [PAR];

  for (genvar gi = 0; gi < FEAT_CNT; gi++) begin : g_feat
    assign feat_arr[gi] = feat_q[gi*FEAT_BITS +: FEAT_BITS];
  end

  always_comb begin
    for (int p = 0; p < PAR; p++) begin
      nsum[PI_W'(p)]  = '0;
      // The last group may run past HIDDEN_CNT; those lanes are idle.
      nlive[PI_W'(p)] = (int'(grp) * PAR + p) < HIDDEN_CNT;
      nidx[PI_W'(p)]  = HI_W'(int'(grp) * PAR + p);
      if (nlive[PI_W'(p)]) begin
        for (int i = 0; i < FEAT_CNT; i++) begin
          if (W1_MASK[W1I_W'((int'(grp) * PAR + p) * FEAT_CNT + i)]) begin
            if (W1_SIGN[W1I_W'((int'(grp) * PAR + p) * FEAT_CNT + i)])
              nsum[PI_W'(p)] = nsum[PI_W'(p)] - $signed(ACC_W'(feat_arr[FI_W'(i)]));
            else
              nsum[PI_W'(p)] = nsum[PI_W'(p)] + $signed(ACC_W'(feat_arr[FI_W'(i)]));
          end
        end
      end
    end
  end

  // Layer 2: score of class cls over all hidden bits.
  logic signed [SCORE_W-1:0] cls_score;
  logic                      take_new;
  logic signed [SCORE_W-1:0] win_score;
  logic [CLS_W-1:0]          win_idx;

  always_comb begin
    cls_score = '0;
    for (int j = 0; j < HIDDEN_CNT; j++) begin
      if (W2_MASK[W2I_W'(int'(cls) * HIDDEN_CNT + j)]) begin
        if (hidden_q[HI_W'(j)] ^ W2_SIGN[W2I_W'(int'(cls) * HIDDEN_CNT + j)])
          cls_score = cls_score + SCORE_W'(1);
        else
          cls_score = cls_score - SCORE_W'(1);
      end
    end
    // Strict greater-than keeps the lowest index on ties.
    take_new  = (cls == '0) || (cls_score > best_score);
    win_score = take_new ? cls_score : best_score;
    win_idx   = take_new ? cls : best_idx;
  end

`ifdef TNN_SCORE_OUT_EN
  logic signed [SCORE_W-1:0] score_q;
  assign score = score_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grp        <= '0;
      cls        <= '0;
      feat_q     <= '0;
      hidden_q   <= '0;
      best_score <= '0;
      best_idx   <= '0;
      prediction <= '0;
      out_valid  <= 1'b0;
`ifdef TNN_SCORE_OUT_EN
      score_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q <= features;
            grp    <= '0;
            state  <= HIDDEN;
          end
        end
        HIDDEN: begin
          for (int p = 0; p < PAR; p++) begin
            if (nlive[PI_W'(p)])
              hidden_q[nidx[PI_W'(p)]] <= !nsum[PI_W'(p)][ACC_W-1];
          end
          if (grp == GRP_W'(G - 1)) begin
            grp   <= '0;
            cls   <= '0;
            state <= CLASS;
          end else begin
            grp <= grp + GRP_W'(1);
          end
        end
        CLASS: begin
          best_score <= win_score;
          best_idx   <= win_idx;
          if (cls == CLS_W'(CLASS_CNT - 1)) begin
            prediction <= win_idx;
            out_valid  <= 1'b1;
            state      <= DONE;
`ifdef TNN_SCORE_OUT_EN
            score_q    <= win_score;
`endif
          end else begin
            cls <= cls + CLS_W'(1);
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tnn_stream.sv
`timescale 1ns/1ps
module tb_seq_tnn_stream;

  localparam int FC  = 12;
  localparam int FB  = 4;
  localparam int HC  = 40;
  localparam int CC  = 6;
  localparam int PAR = 4;
  localparam int G   = (HC + PAR - 1) / PAR;
  localparam int PW  = $clog2(CC);
  localparam int SW  = $clog2(HC) + 2;
  localparam int SHC = 10;
  localparam int SG  = (SHC + PAR - 1) / PAR;

  localparam logic [479:0] W1M = {3{160'h9E37_79B9_7F4A_7C15_F39C_C060_5CED_C834_1082_276B}};
  localparam logic [479:0] W1S = {3{160'hD1B5_4A32_D192_ED03_8B27_2D6A_6E5C_B79A_A3C9_6F17}};
  localparam logic [239:0] W2M = {5{48'hD6B3_5A9C_E127}};
  localparam logic [239:0] W2S = {5{48'h3C5A_96E1_0F7B}};

  // Small engine: neuron 9 = -1 on feature 0, class 1 uses only neuron 9 with sign 1.
  localparam logic [119:0] S_W1M = 120'h1 << 108;
  localparam logic [119:0] S_W1S = 120'h1 << 108;
  localparam logic [59:0]  S_W2M = 60'h1 << 19;
  localparam logic [59:0]  S_W2S = 60'h1 << 19;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [FC*FB-1:0] features, s_features;
  logic in_valid, in_ready, out_valid, out_ready;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [PW-1:0] prediction, s_prediction;
`ifdef TNN_SCORE_OUT_EN
  logic signed [SW-1:0] score;
  logic signed [$clog2(SHC)+1:0] s_score;
`endif

  seq_tnn_stream #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC), .PAR(PAR),
    .W1_MASK(W1M), .W1_SIGN(W1S), .W2_MASK(W2M), .W2_SIGN(W2S)
  ) dut (
    .clk(clk), .rst(rst), .features(features), .in_valid(in_valid),
    .in_ready(in_ready), .prediction(prediction), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef TNN_SCORE_OUT_EN
    , .score(score)
`endif
  );

  seq_tnn_stream #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(SHC), .CLASS_CNT(CC), .PAR(PAR),
    .W1_MASK(S_W1M), .W1_SIGN(S_W1S), .W2_MASK(S_W2M), .W2_SIGN(S_W2S)
  ) dut_small (
    .clk(clk), .rst(rst), .features(s_features), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .prediction(s_prediction), .out_valid(s_out_valid),
    .out_ready(s_out_ready)
`ifdef TNN_SCORE_OUT_EN
    , .score(s_score)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over the weight definitions.
  function automatic void model(input logic [479:0] w1m, input logic [479:0] w1s,
                                input logic [239:0] w2m, input logic [239:0] w2s,
                                input int hc, input logic [47:0] f,
                                output int pred, output int best);
    int h [64];
    int s, sc, fv;
    for (int j = 0; j < hc; j++) begin
      s = 0;
      for (int i = 0; i < FC; i++) begin
        fv = int'((f >> (i*FB)) & 48'hF);
        if (((w1m >> (j*FC+i)) & 480'h1) != 0)
          s += (((w1s >> (j*FC+i)) & 480'h1) != 0) ? -fv : fv;
      end
      h[j] = (s >= 0) ? 1 : 0;
    end
    pred = 0;
    best = 0;
    for (int k = 0; k < CC; k++) begin
      sc = 0;
      for (int j = 0; j < hc; j++) begin
        if (((w2m >> (k*hc+j)) & 240'h1) != 0)
          sc += ((h[j] ^ int'((w2s >> (k*hc+j)) & 240'h1)) != 0) ? 1 : -1;
      end
      if (k == 0 || sc > best) begin
        best = sc;
        pred = k;
      end
    end
  endfunction

  // scoreboard
  int exp_q[$];
  int exp_score_q[$];
  int out_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int p, b;
    if (rst && in_valid && in_ready) begin
      model(W1M, W1S, W2M, W2S, HC, features, p, b);
      exp_q.push_back(p);
      exp_score_q.push_back(b);
    end
    if (rst && out_valid && out_ready) begin
      out_cyc_q.push_back(cyc);
      check_eq("out_has_pending", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        b = exp_score_q.pop_front();
        check_eq("prediction", int'(prediction), p);
`ifdef TNN_SCORE_OUT_EN
        check_eq("score", int'(score), b);
`endif
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_timed(input logic [47:0] f);
    int lat;
    features = f;
    in_valid = 1'b1;
    check_eq("accept_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check_eq("latency", lat, G + CC + 1);
    step();
    check_eq("post_hs_out_valid", int'(out_valid), 0);
    check_eq("post_hs_in_ready", int'(in_ready), 1);
  endtask

  task automatic run_small(input logic [47:0] f, input int exp_pred);
    int lat;
    s_features = f;
    s_in_valid = 1'b1;
    check_eq("small_in_ready", int'(s_in_ready), 1);
    step();
    s_in_valid = 1'b0;
    s_features = '1;
    lat = 1;
    while (!s_out_valid && lat < 100) begin
      step();
      lat++;
    end
    check_eq("small_latency", lat, SG + CC + 1);
    check_eq("small_prediction", int'(s_prediction), exp_pred);
    step();
    check_eq("small_post_in_ready", int'(s_in_ready), 1);
  endtask

  logic [47:0] vec [3];

  initial begin
    int held, n, budget, sp, sb;
    logic rdy;
    logic [47:0] rf;

    rst = 1'b0; in_valid = 1'b0; features = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_features = '0; s_out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_prediction", int'(prediction), 0);
    check_eq("rst_small_out_valid", int'(s_out_valid), 0);
`ifdef TNN_SCORE_OUT_EN
    check_eq("rst_score", int'(score), 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // small engine: directed neuron-9 case, zero-feature case, then random
    run_small({44'h123_4567_89AB, 4'h5}, 1);
    run_small({44'hFED_CBA9_8765, 4'h0}, 0);
    for (int t = 0; t < 3; t++) begin
      rf = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      model({360'b0, S_W1M}, {360'b0, S_W1S}, {180'b0, S_W2M}, {180'b0, S_W2S}, SHC, rf, sp, sb);
      run_small(rf, sp);
    end

    // main engine: latency and result for boundary and random patterns
    send_timed(48'h0);
    send_timed(48'hFFFF_FFFF_FFFF);
    for (int t = 0; t < 3; t++) send_timed({$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF);

    // backpressure
    out_ready = 1'b0;
    features  = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    budget = 0;
    while (!out_valid && budget < 100) begin
      step();
      budget++;
    end
    check_eq("bp_out_valid_seen", int'(out_valid), 1);
    held = int'(prediction);
    features = ~features;
    in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      check_eq("bp_out_valid_hold", int'(out_valid), 1);
      check_eq("bp_prediction_hold", int'(prediction), held);
      check_eq("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("bp_release_out_valid", int'(out_valid), 0);
    check_eq("bp_release_in_ready", int'(in_ready), 1);

    // reset during HIDDEN
    features = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_eq("abort_in_ready", int'(in_ready), 1);
    exp_q.delete();
    exp_score_q.delete();
    step();
    rst = 1'b1;
    send_timed({$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF);

    // back-to-back with in_valid held
    for (int t = 0; t < 3; t++) vec[t] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    out_cyc_q.delete();
    n = 0; budget = 0;
    features = vec[0];
    in_valid = 1'b1;
    while (n < 3 && budget < 200) begin
      rdy = in_ready;
      step();
      budget++;
      if (rdy) begin
        n++;
        if (n < 3) features = vec[n];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_accepted", n, 3);
    budget = 0;
    while (out_cyc_q.size() < 3 && budget < 200) begin
      step();
      budget++;
    end
    step();
    check_eq("b2b_pulses", out_cyc_q.size(), 3);
    if (out_cyc_q.size() >= 3) begin
      check_eq("b2b_gap1", out_cyc_q[1] - out_cyc_q[0], G + CC + 2);
      check_eq("b2b_gap2", out_cyc_q[2] - out_cyc_q[1], G + CC + 2);
    end

    // random vectors with random downstream stalls
    for (int t = 0; t < 20; t++) begin
      budget = 0;
      while (!in_ready && budget < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        budget++;
      end
      features = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      budget = 0;
      while (exp_q.size() != 0 && budget < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        budget++;
      end
      check_eq("rand_drained", exp_q.size(), 0);
    end
    out_ready = 1'b1;
    step();
    step();

    check_eq("final_exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_tnn_stream.md
Name: seq_tnn_stream

Overview:
- Parametrised successor to the fixed sparse ternary inference wrapper: a streaming two-layer ternary neural network engine with valid/ready handshakes on input and output.
- Evaluates PAR hidden neurons per cycle, then scores classes one per cycle with a running argmax.
- Weights are elaboration-time parameters (dense mask/sign encoding), so one RTL body serves every dataset product.
- Sits directly under each per-dataset top, between the feature register and the prediction output.

Parameters:
- FEAT_CNT, 12, number of input features
- FEAT_BITS, 4, unsigned bits per feature
- HIDDEN_CNT, 40, hidden neurons
- CLASS_CNT, 6, output classes
- PAR, 4, hidden neurons evaluated per cycle (1..HIDDEN_CNT)
- W1_MASK, 0, FEAT_CNT*HIDDEN_CNT bits; bit j*FEAT_CNT+i = 1 means weight(i,j) is nonzero
- W1_SIGN, 0, same layout; 1 = -1, 0 = +1; ignored where the mask bit is 0
- W2_MASK, 0, HIDDEN_CNT*CLASS_CNT bits; bit k*HIDDEN_CNT+j
- W2_SIGN, 0, same layout as W2_MASK

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- features  in  FEAT_CNT*FEAT_BITS  feature i at bits [i*FEAT_BITS +: FEAT_BITS]
- in_valid  in  1  features valid
- in_ready  out  1  engine accepts a new vector
- prediction  out  clog2(CLASS_CNT)  winning class index
- out_valid  out  1  prediction valid
- out_ready  in  1  downstream accepts the prediction

Behaviour:
- Reset (rst=0, async): state IDLE, in_ready=1, out_valid=0, prediction=0, all counters and accumulators 0.
- FSM IDLE -> HIDDEN -> CLASS -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch features, grp=0, go to HIDDEN.
- HIDDEN:
  - Each cycle computes neurons j = grp*PAR .. grp*PAR+PAR-1.
  - Each neuron: s_j = signed sum over i of (mask ? (sign ? -f_i : +f_i) : 0).
  - Accumulator width is FEAT_BITS+clog2(FEAT_CNT)+1, signed, and cannot overflow.
  - Stores h_j = (s_j >= 0) in the hidden bit register.
  - Neurons with j >= HIDDEN_CNT (last partial group) are not computed or stored.
  - Runs G = ceil(HIDDEN_CNT/PAR) cycles, then cls=0 and go to CLASS.
- CLASS:
  - One class per cycle: score_k = sum over j of (mask ? ((h_j XOR sign) ? +1 : -1) : 0).
  - Score width is clog2(HIDDEN_CNT)+2, signed.
  - At cls=0 the best register is loaded unconditionally.
  - Afterwards best is replaced only if score_k > best (strict), so ties go to the lowest index.
  - After cls = CLASS_CNT-1, prediction <= best index, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1; prediction is held stable until out_ready=1.
  - On out_valid&out_ready: out_valid=0 next cycle, go to IDLE.
  - in_ready=0 in all states except IDLE.
- Latency: accept at cycle 0; out_valid rises at cycle G+CLASS_CNT+1.
  - Throughput is one vector per G+CLASS_CNT+2 cycles with out_ready held at 1.
- in_valid outside IDLE is ignored; the features bus is only sampled at accept.
- Reset asserted mid-operation aborts immediately with no output; the partial result is discarded.
- prediction keeps its last value after the DONE handshake; it is only meaningful while out_valid=1.

Optional Feature:
- TNN_SCORE_OUT_EN defined: adds output port score (clog2(HIDDEN_CNT)+2 bits, signed), holding the winning class score.
  - score updates with prediction and resets to 0.
- Not defined: the port is absent and no score register is kept beyond the internal best register.

Test Plan:
- All-zero weights, default params, features=any, out_ready=1 -> out_valid at cycle 17 (G=10, +6, +1), prediction=0 (all scores 0, tie to lowest); score=0 if TNN_SCORE_OUT_EN.
- W2_MASK bits for class 3 all 1, W2_SIGN=0, W1 all zero -> all h=1, score_3=40, prediction=3.
- HIDDEN_CNT=10, PAR=4, W1 neuron 9 = -1 on feature 0, feature 0=5, W2 class 1 uses only neuron 9 with sign 1 -> h_9=0, score_1=+1, prediction=1; out_valid at cycle 3+6+1=10; the unused neurons 10/11 have no effect.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> prediction/out_valid stable, in_ready=0, a new in_valid is not accepted; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset pulse during HIDDEN (cycle 4) -> out_valid=0, in_ready=1 immediately; next vector completes with normal latency and correct result.
- Back-to-back: in_valid held 1 with 3 vectors, out_ready=1 -> exactly 3 out_valid pulses, 18 cycles apart, each matching the golden model.
